// File: rtl/pll_pkg.sv
// Shared types, defaults and the window tolerance check for the PLL lock detector.
package pll_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitEdge,
    StAcquire,
    StLocked
  } pll_state_e;

  localparam int unsigned DefRatio = 8;
  localparam int unsigned DefTol   = 1;

  // |len - ratio| <= tol, arranged so that neither side can wrap.
  function automatic logic in_tol(input int unsigned len, input int unsigned ratio,
                                  input int unsigned tol);
    return ((len + tol) >= ratio) && (len <= (ratio + tol));
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module pll_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: counts CLK cycles per REF period and tracks lock with hysteresis.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int unsigned RATIO        = DefRatio,
  parameter int unsigned TOL          = DefTol,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             EN_VCO,
  input  logic             REF,
  output logic             LOCK,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic             MEAS_VALID,
  output logic             WIN_ERR
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W:0]   LenOne   = (CNT_W + 1)'(1);
  localparam logic [GoodW-1:0] GoodOne  = GoodW'(1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_COUNT - 1);
  localparam logic [BadW-1:0]  BadOne   = BadW'(1);
  localparam logic [BadW-1:0]  BadLast  = BadW'(UNLOCK_COUNT - 1);

  logic ref_s, en_s, ref_d_q, ref_rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   len;
  logic [CNT_W-1:0] len_clip;
  logic             win_good, active, measure, timeout;

  pll_state_e       state_q;
  logic [GoodW-1:0] good_cnt_q;
  logic [BadW-1:0]  bad_cnt_q;
  // Set after a timeout while locked: the next edge only reopens a window.
  logic             resync_q;
  logic             lock_q, meas_valid_q, win_err_q;
  logic [CNT_W-1:0] period_q;

  pll_sync2 u_sync_ref (
    .clk_i (CLK),
    .rst_i (reset),
    .d_i   (REF),
    .q_o   (ref_s)
  );

  pll_sync2 u_sync_en (
    .clk_i (CLK),
    .rst_i (reset),
    .d_i   (EN_VCO),
    .q_o   (en_s)
  );

  // Delayed copy of synchronized REF for rising-edge detection.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ref_d_q <= 1'b0;
    end else begin
      ref_d_q <= ref_s;
    end
  end

  assign ref_rise = ref_s & ~ref_d_q;

  // Period counter: restarts on every edge, saturates to flag a stalled REF.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!en_s || (state_q == StIdle) || ref_rise) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  // Window length is one more than the count; a saturated window clips to CntMax.
  assign len      = {1'b0, cnt_q} + LenOne;
  assign len_clip = len[CNT_W] ? CntMax : len[CNT_W-1:0];
  assign win_good = in_tol(32'(len), RATIO, TOL);

  assign active  = (state_q == StAcquire) || (state_q == StLocked);
  assign measure = ref_rise && active && !resync_q;
  // An edge in the same cycle as saturation is a measurement, not a timeout.
  assign timeout = !ref_rise && active && !resync_q && (cnt_q == CntMax);

  // Lock FSM with registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      resync_q     <= 1'b0;
      lock_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      win_err_q    <= 1'b0;
      period_q     <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      win_err_q    <= 1'b0;
      if (measure) begin
        meas_valid_q <= 1'b1;
        period_q     <= len_clip;
        win_err_q    <= !win_good;
      end else if (timeout) begin
        win_err_q <= 1'b1;
      end

      if (!en_s) begin
        state_q    <= StIdle;
        good_cnt_q <= '0;
        bad_cnt_q  <= '0;
        resync_q   <= 1'b0;
        lock_q     <= 1'b0;
        meas_valid_q <= 1'b0;
        win_err_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StWaitEdge;
          end
          StWaitEdge: begin
            if (ref_rise) begin
              state_q <= StAcquire;
            end
          end
          StAcquire: begin
            if (measure) begin
              if (!win_good) begin
                good_cnt_q <= '0;
              end else if (good_cnt_q == GoodLast) begin
                state_q    <= StLocked;
                lock_q     <= 1'b1;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
              end else begin
                good_cnt_q <= good_cnt_q + GoodOne;
              end
            end else if (timeout) begin
              state_q    <= StWaitEdge;
              good_cnt_q <= '0;
            end
          end
          StLocked: begin
            if (ref_rise && resync_q) begin
              resync_q <= 1'b0;
            end
            if (measure || timeout) begin
              if (measure && win_good) begin
                bad_cnt_q <= '0;
              end else if (bad_cnt_q == BadLast) begin
                // A stall needs a fresh first edge; a bad measurement already has one.
                state_q    <= timeout ? StWaitEdge : StAcquire;
                lock_q     <= 1'b0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                resync_q   <= 1'b0;
              end else begin
                bad_cnt_q <= bad_cnt_q + BadOne;
                resync_q  <= timeout;
              end
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign LOCK       = lock_q;
  assign PERIOD_CNT = period_q;
  assign MEAS_VALID = meas_valid_q;
  assign WIN_ERR    = win_err_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: table-driven REF windows checked through a scoreboard queue.
module tb_pll_lock_detect;

  logic       CLK = 1'b0;
  logic       reset;
  logic       EN_VCO;
  logic       REF;
  logic       LOCK;
  logic [7:0] PERIOD_CNT;
  logic       MEAS_VALID;
  logic       WIN_ERR;

  pll_lock_detect dut (
    .CLK        (CLK),
    .reset      (reset),
    .EN_VCO     (EN_VCO),
    .REF        (REF),
    .LOCK       (LOCK),
    .PERIOD_CNT (PERIOD_CNT),
    .MEAS_VALID (MEAS_VALID),
    .WIN_ERR    (WIN_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int period;
    bit err;
    bit lock;
  } win_t;

  typedef struct {
    bit         meas;
    logic [7:0] period;
    bit         err;
    bit         lock;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_period = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every output event must match the oldest expectation in the queue.
  always @(negedge CLK) begin
    if (!reset && (MEAS_VALID || WIN_ERR)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: meas=%0b err=%0b period=%0d, nothing expected (t=%0t)",
                 MEAS_VALID, WIN_ERR, PERIOD_CNT, $time);
      end else begin
        mon_e = sb.pop_front();
        check("meas_valid", MEAS_VALID, mon_e.meas);
        check("period_cnt", PERIOD_CNT, mon_e.period);
        check("win_err", WIN_ERR, mon_e.err);
        check("lock_at_event", LOCK, mon_e.lock);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic first_edge();
    REF = 1'b0;
    cycles(3);
    REF = 1'b1;
  endtask

  // One REF period of p CLK cycles; the closing rising edge yields a measurement.
  task automatic window(input int p, input bit err, input bit lock);
    exp_t e;
    cycles(p / 2);
    REF = 1'b0;
    cycles(p - p / 2);
    REF = 1'b1;
    e.meas   = 1'b1;
    e.period = (p > 255) ? 8'd255 : 8'(p);
    e.err    = err;
    e.lock   = lock;
    last_period = e.period;
    sb.push_back(e);
  endtask

  task automatic expect_timeout(input bit lock);
    exp_t e;
    e.meas   = 1'b0;
    e.period = last_period;
    e.err    = 1'b1;
    e.lock   = lock;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic relock_run();
    first_edge();
    window(8, 1'b0, 1'b0);
    window(8, 1'b0, 1'b0);
    window(8, 1'b0, 1'b0);
    window(8, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    win_t tbl[26];
    tbl = '{
      '{8,   1'b0, 1'b0}, '{8,   1'b0, 1'b0}, '{8,   1'b0, 1'b0}, '{8,   1'b0, 1'b1},
      '{8,   1'b0, 1'b1}, '{12,  1'b1, 1'b1}, '{8,   1'b0, 1'b1}, '{5,   1'b1, 1'b1},
      '{5,   1'b1, 1'b0}, '{7,   1'b0, 1'b0}, '{9,   1'b0, 1'b0}, '{7,   1'b0, 1'b0},
      '{9,   1'b0, 1'b1}, '{6,   1'b1, 1'b1}, '{10,  1'b1, 1'b0}, '{8,   1'b0, 1'b0},
      '{8,   1'b0, 1'b0}, '{6,   1'b1, 1'b0}, '{8,   1'b0, 1'b0}, '{8,   1'b0, 1'b0},
      '{8,   1'b0, 1'b0}, '{8,   1'b0, 1'b1}, '{256, 1'b1, 1'b1}, '{8,   1'b0, 1'b1},
      '{255, 1'b1, 1'b1}, '{8,   1'b0, 1'b1}
    };

    reset  = 1'b1;
    EN_VCO = 1'b0;
    REF    = 1'b0;
    cycles(3);
    check("reset_lock", LOCK, 0);
    check("reset_period", PERIOD_CNT, 0);
    check("reset_meas_valid", MEAS_VALID, 0);
    check("reset_win_err", WIN_ERR, 0);

    reset  = 1'b0;
    EN_VCO = 1'b1;
    cycles(6);
    first_edge();
    for (int i = 0; i < 26; i++) begin
      window(tbl[i].period, tbl[i].err, tbl[i].lock);
    end
    drain();
    check("locked_after_table", LOCK, 1);

    // First stall: one WIN_ERR, lock held, no repeat while REF stays quiet.
    expect_timeout(1'b1);
    cycles(400);
    drain();
    check("lock_after_stall1", LOCK, 1);

    // Fresh edge only reopens the window; second stall drops lock.
    first_edge();
    expect_timeout(1'b0);
    cycles(400);
    drain();
    check("lock_after_stall2", LOCK, 0);

    relock_run();
    check("relock_after_stall", LOCK, 1);

    // Drop EN_VCO mid-window.
    cycles(2);
    EN_VCO = 1'b0;
    REF    = 1'b0;
    cycles(3);
    @(negedge CLK);
    check("lock_after_en_drop", LOCK, 0);
    check("period_held_en_drop", PERIOD_CNT, last_period);
    cycles(4);
    EN_VCO = 1'b1;
    cycles(6);
    relock_run();
    check("relock_after_en", LOCK, 1);

    // Reset mid-window clears LOCK asynchronously.
    cycles(2);
    #2;
    reset = 1'b1;
    REF   = 1'b0;
    #1;
    check("lock_async_reset", LOCK, 0);
    check("period_async_reset", PERIOD_CNT, 0);
    cycles(2);
    reset = 1'b0;
    last_period = 8'd0;
    cycles(6);
    first_edge();
    window(8, 1'b0, 1'b0);
    window(9, 1'b0, 1'b0);
    window(8, 1'b0, 1'b0);
    window(7, 1'b0, 1'b1);
    drain();
    check("relock_after_reset", LOCK, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
